// File: rtl/tagged_stream_arbiter_if.sv
// rtl/tagged_stream_arbiter_if.sv - tagged input and merged output stream interfaces
interface tagged_i #(
    parameter type data_t    = logic [7:0],
    parameter int  TAG_WIDTH = 4
);
    data_t                data;
    logic                 keep;
    logic                 last;
    logic                 valid;
    logic                 ready;
    logic [TAG_WIDTH-1:0] tag;

    modport m (output data, keep, last, valid, tag, input ready);
    modport s (input data, keep, last, valid, tag, output ready);
endinterface

interface data_i #(
    parameter type data_t = logic [7:0]
);
    data_t data;
    logic  keep;
    logic  last;
    logic  valid;
    logic  ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/tagged_stream_arbiter.sv
// rtl/tagged_stream_arbiter.sv - N-to-1 tag-filtered round-robin stream arbiter with 2-entry output FIFO
module tagged_stream_arbiter #(
    parameter type                  data_t      = logic [7:0],
    parameter int                   TAG_WIDTH   = 4,
    parameter logic [TAG_WIDTH-1:0] ID          = '0,
    parameter logic [TAG_WIDTH-1:0] ID_MASK     = '1,
    parameter int                   NUM_INPUTS  = 4,
    parameter int                   ARB_MODE    = 0,
    parameter int                   QUANTUM     = 1,
    parameter int                   FILTER_KEEP = 1,
    parameter int                   SRC_WIDTH   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tagged_i.s                   in [NUM_INPUTS],
    data_i.m                     out,
    output logic [SRC_WIDTH-1:0] out_src,
    output logic                 busy
);

    localparam int QW = $clog2(QUANTUM + 1);

    typedef logic [SRC_WIDTH-1:0] idx_t;
    typedef logic [QW-1:0]        qcnt_t;
    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    typedef struct packed {
        data_t data;
        logic  keep;
        logic  last;
        idx_t  src;
    } entry_t;

    localparam qcnt_t QMAX = qcnt_t'(QUANTUM);

    function automatic idx_t next_idx(input idx_t g);
        if (int'(g) >= NUM_INPUTS - 1) return '0;
        return g + 1'b1;
    endfunction

    logic [NUM_INPUTS-1:0] in_valid;
    logic [NUM_INPUTS-1:0] in_keep;
    logic [NUM_INPUTS-1:0] in_last;
    logic [NUM_INPUTS-1:0] match;
    logic [NUM_INPUTS-1:0] drop;
    logic [NUM_INPUTS-1:0] cand;
    logic [NUM_INPUTS-1:0] in_ready;
    data_t                 in_data [NUM_INPUTS];

    state_t state_q, state_d;
    idx_t   lock_q, lock_d;
    idx_t   ptr_q, ptr_d;
    qcnt_t  qcnt_q, qcnt_d;
    qcnt_t  q_inc;
    logic   busy_q;

    entry_t    mem [2];
    logic      rd_q, wr_q;
    logic [1:0] count_q, count_d;
    entry_t    head;
    entry_t    wr_entry;

    logic                  scan_ok;
    idx_t                  scan_idx;
    logic                  grant_ok;
    idx_t                  grant_idx;
    logic [NUM_INPUTS-1:0] grant_mask;
    logic                  others;
    logic                  space;
    logic                  accept;
    logic                  pop;

    // Drop elements bypass arbitration, except a packet-mode last which must still close the packet.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
        assign in_valid[i] = in[i].valid;
        assign in_keep[i]  = in[i].keep;
        assign in_last[i]  = in[i].last;
        assign in_data[i]  = in[i].data;
        assign match[i]    = ((in[i].tag ^ ID) & ID_MASK) == '0;
        assign drop[i]     = match[i] && (FILTER_KEEP != 0) && !in[i].keep
                             && !((ARB_MODE == 1) && in[i].last);
        assign cand[i]     = in[i].valid && match[i] && !drop[i];
        assign in_ready[i] = rst_n && in[i].valid
                             && (!match[i] || drop[i]
                                 || (grant_ok && (grant_idx == idx_t'(i)) && space));
        assign in[i].ready = in_ready[i];
    end

    always_comb begin : scan
        int pos;
        scan_ok  = 1'b0;
        scan_idx = '0;
        pos      = 0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= NUM_INPUTS) pos = pos - NUM_INPUTS;
            if (!scan_ok && cand[idx_t'(pos)]) begin
                scan_ok  = 1'b1;
                scan_idx = idx_t'(pos);
            end
        end
    end

    always_comb begin
        grant_ok  = scan_ok;
        grant_idx = scan_idx;
        if ((ARB_MODE == 1) && (state_q == S_LOCKED)) begin
            grant_ok  = cand[lock_q];
            grant_idx = lock_q;
        end
        grant_mask            = '0;
        grant_mask[grant_idx] = 1'b1;
        others = |(cand & ~grant_mask);
    end

    // Space comes from the registered count only, keeping out.ready off the in.ready path.
    assign space  = (count_q != 2'd2);
    assign accept = grant_ok && space;
    assign pop    = out.valid && out.ready;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        qcnt_d  = qcnt_q;
        q_inc   = '0;
        if (accept) begin
            if (ARB_MODE == 1) begin
                if (in_last[grant_idx]) begin
                    state_d = S_IDLE;
                    ptr_d   = next_idx(grant_idx);
                end else begin
                    state_d = S_LOCKED;
                    lock_d  = grant_idx;
                end
            end else begin
                // A grant that skipped past ptr starts a fresh quantum for the new holder.
                if (grant_idx != ptr_q)  q_inc = qcnt_t'(1);
                else if (qcnt_q >= QMAX) q_inc = qcnt_q;
                else                     q_inc = qcnt_q + 1'b1;
                if ((q_inc >= QMAX) && others) begin
                    ptr_d  = next_idx(grant_idx);
                    qcnt_d = '0;
                end else begin
                    ptr_d  = grant_idx;
                    qcnt_d = q_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lock_q  <= '0;
            ptr_q   <= '0;
            qcnt_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            qcnt_q  <= qcnt_d;
            busy_q  <= (state_d == S_LOCKED) || (count_d != 2'd0);
        end
    end

    always_comb begin
        wr_entry.data = in_data[grant_idx];
        wr_entry.keep = in_keep[grant_idx];
        wr_entry.last = in_last[grant_idx];
        wr_entry.src  = grant_idx;
    end

    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (accept) begin
                mem[wr_q] <= wr_entry;
                wr_q      <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            count_q <= count_d;
        end
    end

    assign head      = mem[rd_q];
    assign out.valid = (count_q != 2'd0);
    assign out.data  = head.data;
    assign out.keep  = head.keep;
    assign out.last  = head.last;
    assign out_src   = head.src;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tagged_stream_arbiter.sv
// tb/tb_tagged_stream_arbiter.sv - directed self-checking bench for tagged_stream_arbiter
module tb_tagged_stream_arbiter;
    typedef logic [7:0] data_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] v, k, l;
    data_t      d  [4];
    logic [3:0] tg [4];
    logic       ordy;

    int checks = 0;
    int errors = 0;

    // a: element Q=1 ID=0; b: element Q=3 ID=0; c: packet ID=4 mask F; e: element ID=4 mask E
    tagged_i #(.data_t(data_t), .TAG_WIDTH(4)) a_in [4] ();
    tagged_i #(.data_t(data_t), .TAG_WIDTH(4)) b_in [4] ();
    tagged_i #(.data_t(data_t), .TAG_WIDTH(4)) c_in [4] ();
    tagged_i #(.data_t(data_t), .TAG_WIDTH(4)) e_in [4] ();
    data_i #(.data_t(data_t)) a_out ();
    data_i #(.data_t(data_t)) b_out ();
    data_i #(.data_t(data_t)) c_out ();
    data_i #(.data_t(data_t)) e_out ();

    logic [3:0] a_r, b_r, c_r, e_r;
    logic [1:0] a_src, b_src, c_src, e_src;
    logic       a_busy, b_busy, c_busy, e_busy;

    for (genvar i = 0; i < 4; i++) begin : g_drv
        assign a_in[i].valid = v[i];
        assign a_in[i].data  = d[i];
        assign a_in[i].keep  = k[i];
        assign a_in[i].last  = l[i];
        assign a_in[i].tag   = tg[i];
        assign a_r[i]        = a_in[i].ready;
        assign b_in[i].valid = v[i];
        assign b_in[i].data  = d[i];
        assign b_in[i].keep  = k[i];
        assign b_in[i].last  = l[i];
        assign b_in[i].tag   = tg[i];
        assign b_r[i]        = b_in[i].ready;
        assign c_in[i].valid = v[i];
        assign c_in[i].data  = d[i];
        assign c_in[i].keep  = k[i];
        assign c_in[i].last  = l[i];
        assign c_in[i].tag   = tg[i];
        assign c_r[i]        = c_in[i].ready;
        assign e_in[i].valid = v[i];
        assign e_in[i].data  = d[i];
        assign e_in[i].keep  = k[i];
        assign e_in[i].last  = l[i];
        assign e_in[i].tag   = tg[i];
        assign e_r[i]        = e_in[i].ready;
    end

    assign a_out.ready = ordy;
    assign b_out.ready = ordy;
    assign c_out.ready = ordy;
    assign e_out.ready = ordy;

    tagged_stream_arbiter #(.data_t(data_t), .TAG_WIDTH(4), .ID(4'h0), .ID_MASK(4'hF),
        .NUM_INPUTS(4), .ARB_MODE(0), .QUANTUM(1), .FILTER_KEEP(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in(a_in), .out(a_out), .out_src(a_src), .busy(a_busy));
    tagged_stream_arbiter #(.data_t(data_t), .TAG_WIDTH(4), .ID(4'h0), .ID_MASK(4'hF),
        .NUM_INPUTS(4), .ARB_MODE(0), .QUANTUM(3), .FILTER_KEEP(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in(b_in), .out(b_out), .out_src(b_src), .busy(b_busy));
    tagged_stream_arbiter #(.data_t(data_t), .TAG_WIDTH(4), .ID(4'h4), .ID_MASK(4'hF),
        .NUM_INPUTS(4), .ARB_MODE(1), .QUANTUM(1), .FILTER_KEEP(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in(c_in), .out(c_out), .out_src(c_src), .busy(c_busy));
    tagged_stream_arbiter #(.data_t(data_t), .TAG_WIDTH(4), .ID(4'h4), .ID_MASK(4'hE),
        .NUM_INPUTS(4), .ARB_MODE(0), .QUANTUM(1), .FILTER_KEEP(1)) u_e (
        .clk(clk), .rst_n(rst_n), .in(e_in), .out(e_out), .out_src(e_src), .busy(e_busy));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        v    = 4'h0;
        k    = 4'hF;
        l    = 4'h0;
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d[i]  = 8'h00;
            tg[i] = 4'h0;
        end
    endtask

    task automatic reset_phase();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    int seq1 [5] = '{0, 1, 2, 3, 0};
    int seq2 [7] = '{1, 1, 1, 2, 2, 2, 1};

    initial begin
        // Reset state, with every input presenting a valid element
        rst_n = 1'b0;
        idle_inputs();
        v = 4'hF;
        #1;
        check("rst_ready_a", a_r, 4'b0000);
        check("rst_ready_c", c_r, 4'b0000);
        tick();
        check("rst_valid", a_out.valid, 1'b0);
        check("rst_keep", a_out.keep, 1'b0);
        check("rst_last", a_out.last, 1'b0);
        check("rst_src", a_src, 2'd0);
        check("rst_busy_a", a_busy, 1'b0);
        check("rst_busy_c", c_busy, 1'b0);

        // Element mode, quantum 1, all four inputs contending
        reset_phase();
        v = 4'hF;
        for (int i = 0; i < 4; i++) d[i] = data_t'(8'h10 + i);
        #1;
        check("e1_ready_first", a_r, 4'b0001);
        for (int n = 0; n < 5; n++) begin
            tick();
            check($sformatf("e1_valid_%0d", n), a_out.valid, 1'b1);
            check($sformatf("e1_src_%0d", n), a_src, seq1[n]);
            check($sformatf("e1_data_%0d", n), a_out.data, 8'h10 + seq1[n]);
        end
        check("e1_busy", a_busy, 1'b1);

        // Element mode, quantum 3, inputs 1 and 2; then input 2 alone
        reset_phase();
        v = 4'b0110;
        #1;
        check("q3_ready_first", b_r, 4'b0010);
        for (int n = 0; n < 7; n++) begin
            tick();
            check($sformatf("q3_valid_%0d", n), b_out.valid, 1'b1);
            check($sformatf("q3_src_%0d", n), b_src, seq2[n]);
        end
        v = 4'b0100;
        for (int n = 0; n < 4; n++) begin
            tick();
            check($sformatf("q3_solo_valid_%0d", n), b_out.valid, 1'b1);
            check($sformatf("q3_solo_src_%0d", n), b_src, 2'd2);
        end

        // Packet mode: input 0 packet with a bubble, input 3 contending
        reset_phase();
        tg[0] = 4'h4;
        tg[3] = 4'h4;
        v     = 4'b1001;
        l     = 4'b1000;
        d[0]  = 8'hA0;
        d[3]  = 8'hB0;
        #1;
        check("pk_ready_first", c_r, 4'b0001);
        tick();
        check("pk_src_a0", c_src, 2'd0);
        check("pk_data_a0", c_out.data, 8'hA0);
        check("pk_busy_locked", c_busy, 1'b1);
        d[0] = 8'hA1;
        #1;
        check("pk_ready_locked", c_r, 4'b0001);
        tick();
        check("pk_data_a1", c_out.data, 8'hA1);
        v[0] = 1'b0;
        #1;
        check("pk_ready_bubble", c_r, 4'b0000);
        tick();
        check("pk_valid_bubble", c_out.valid, 1'b0);
        check("pk_busy_bubble", c_busy, 1'b1);
        v[0] = 1'b1;
        l[0] = 1'b1;
        d[0] = 8'hA2;
        #1;
        check("pk_ready_last", c_r, 4'b0001);
        tick();
        check("pk_data_a2", c_out.data, 8'hA2);
        check("pk_last_a2", c_out.last, 1'b1);
        check("pk_src_a2", c_src, 2'd0);
        v[0] = 1'b0;
        #1;
        check("pk_next_grant", c_r, 4'b1000);
        tick();
        check("pk_src_b0", c_src, 2'd3);
        check("pk_data_b0", c_out.data, 8'hB0);

        // Tag masking and keep=0 handling on input 1
        reset_phase();
        v     = 4'b0010;
        tg[1] = 4'h5;
        d[1]  = 8'h55;
        #1;
        check("mask_e_ready", e_r, 4'b0010);
        check("mask_f_consumed", c_r, 4'b0010);
        tick();
        check("mask_e_valid", e_out.valid, 1'b1);
        check("mask_e_src", e_src, 2'd1);
        check("mask_e_data", e_out.data, 8'h55);
        check("mask_f_no_out", c_out.valid, 1'b0);
        tg[1] = 4'h4;
        k[1]  = 1'b0;
        l[1]  = 1'b1;
        d[1]  = 8'h66;
        #1;
        check("pk_keep0_ready", c_r, 4'b0010);
        check("el_keep0_ready", e_r, 4'b0010);
        tick();
        check("pk_keep0_valid", c_out.valid, 1'b1);
        check("pk_keep0_keep", c_out.keep, 1'b0);
        check("pk_keep0_last", c_out.last, 1'b1);
        check("pk_keep0_src", c_src, 2'd1);
        check("pk_keep0_data", c_out.data, 8'h66);
        check("el_keep0_dropped", e_out.valid, 1'b0);

        // Backpressure for 4 cycles under full load, input 3 non-matching
        reset_phase();
        v     = 4'hF;
        tg[3] = 4'hF;
        for (int i = 0; i < 4; i++) d[i] = data_t'(8'h30 + i);
        ordy = 1'b0;
        #1;
        check("bp_ready_c1", a_r, 4'b1001);
        tick();
        check("bp_ready_c2", a_r, 4'b1010);
        tick();
        check("bp_full_c3", a_r, 4'b1000);
        tick();
        check("bp_full_c4", a_r, 4'b1000);
        tick();
        check("bp_hold_valid", a_out.valid, 1'b1);
        check("bp_hold_src", a_src, 2'd0);
        check("bp_hold_data", a_out.data, 8'h30);
        check("bp_hold_ready", a_r, 4'b1000);
        ordy = 1'b1;
        #1;
        check("bp_no_comb_path", a_r, 4'b1000);
        tick();
        check("bp_rel_src1", a_src, 2'd1);
        check("bp_rel_data1", a_out.data, 8'h31);
        check("bp_rel_ready", a_r, 4'b1100);
        tick();
        check("bp_rel_src2", a_src, 2'd2);
        check("bp_rel_data2", a_out.data, 8'h32);

        // Asynchronous reset mid-packet with the FIFO full
        reset_phase();
        tg[0] = 4'h4;
        v     = 4'b0001;
        d[0]  = 8'hC0;
        ordy  = 1'b0;
        tick();
        d[0] = 8'hC1;
        tick();
        check("mid_valid", c_out.valid, 1'b1);
        check("mid_busy", c_busy, 1'b1);
        check("mid_full_ready", c_r, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", c_out.valid, 1'b0);
        check("rst_async_busy", c_busy, 1'b0);
        check("rst_async_ready", c_r, 4'b0000);
        v     = 4'b1001;
        tg[3] = 4'h4;
        l     = 4'b1001;
        d[0]  = 8'hD0;
        d[3]  = 8'hD3;
        ordy  = 1'b1;
        rst_n = 1'b1;
        #1;
        check("rst_first_grant", c_r, 4'b0001);
        tick();
        check("rst_first_src", c_src, 2'd0);
        check("rst_first_data", c_out.data, 8'hD0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
